// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the program loader: data/address widths, the
//   instruction-memory depth, the loader FSM state type and the width of the
//   internal byte counter.
package program_loader_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MEM_DEPTH = 256;

  // One extra bit over the address so a 256-byte load can count to 256
  // without wrapping back to zero.
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader
//   Receives a byte stream (length, payload, checksum) and writes the payload
//   into instruction memory, holding the CPU in reset while memory is being
//   written or holds an image that failed its checksum.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   begin a load (honoured in IDLE or ERROR only)
//   in_valid  in   in_data valid this cycle
//   in_data   in   stream byte: length (0 = 256), payload, checksum
//   in_ready  out  loader accepts a byte (function of state only)
//   mem_we    out  memory write strobe, one cycle after each payload handshake
//   mem_addr  out  memory write address
//   mem_data  out  memory write data
//   cpu_hold  out  CPU held in reset (LEN, DATA, CHECK, ERROR)
//   busy      out  load in progress (LEN, DATA, CHECK)
//   done      out  one-cycle pulse on a successful load
//   error     out  checksum failure, held until the next start or reset
module program_loader
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  len;
  logic [DATA_W-1:0] sum;

  logic              hs;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] sum_next;

  always_comb begin
    busy       = (state == S_LEN) || (state == S_DATA) || (state == S_CHECK);
    in_ready   = busy;
    cpu_hold   = busy || (state == S_ERROR);
    done       = (state == S_DONE);
    error      = (state == S_ERROR);
    hs         = in_valid && in_ready;
    count_next = count + 1'b1;
    sum_next   = sum + in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      count    <= '0;
      len      <= '0;
      sum      <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_LEN;
        end
        S_LEN: begin
          if (hs) begin
            // A length byte of zero encodes a full 256-byte image.
            len   <= (in_data == '0) ? CNT_W'(MEM_DEPTH) : {1'b0, in_data};
            count <= '0;
            sum   <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (hs) begin
            mem_we   <= 1'b1;
            mem_addr <= count[ADDR_W-1:0];
            mem_data <= in_data;
            sum      <= sum_next;
            count    <= count_next;
            if (count_next == len) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hs) state <= (sum_next == '0) ? S_DONE : S_ERROR;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_ERROR: begin
          if (start) state <= S_LEN;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed testbench for program_loader. Inputs change 1 ns after the rising
//   edge; a negedge monitor logs every memory write and done pulse.
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;

  int tests_run;
  int tests_failed;

  logic [7:0] wr_addr [0:1023];
  logic [7:0] wr_data [0:1023];
  int         wr_n;
  int         done_n;

  program_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    wr_n   = 0;
    done_n = 0;
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1 && wr_n < 1024) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_data;
      wr_n = wr_n + 1;
    end
    if (done === 1'b1) done_n = done_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] exp_o;
    logic [8:0] got_o;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    // {in_ready, mem_we, cpu_hold, busy, done, error, 3'b0}
    got_o = {in_ready, mem_we, cpu_hold, busy, done, error, 3'b000};
    exp_o = 9'b0;
    tests_run++;
    if (got_o !== exp_o) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b exp=%b", got_o, exp_o);
    end
    tests_run++;
    if ({mem_addr, mem_data} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_mem_bus got=%h exp=0000", {mem_addr, mem_data});
    end
    // IDLE does not accept bytes even with in_valid high.
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({in_ready, busy, mem_we} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_ignores_data got=%b exp=000", {in_ready, busy, mem_we});
    end
  endtask

  task automatic test_nominal();
    int wb;
    int db;
    logic [7:0] pay [0:2];
    pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30;
    wb = wr_n;
    db = done_n;
    pulse_start();
    tests_run++;
    if ({in_ready, busy, cpu_hold, done, error} !== 5'b11100) begin
      tests_failed++;
      $display("FAIL nominal_len_outputs got=%b exp=11100", {in_ready, busy, cpu_hold, done, error});
    end
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_byte(pay[i]);
    // Now in CHECK: the last write is on the bus this cycle.
    tests_run++;
    if ({mem_we, mem_addr, mem_data, busy, cpu_hold} !== {1'b1, 8'h02, 8'h30, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL nominal_check_cycle got we=%b addr=%h data=%h busy=%b hold=%b exp we=1 addr=02 data=30 busy=1 hold=1",
               mem_we, mem_addr, mem_data, busy, cpu_hold);
    end
    send_byte(8'hA0);
    tests_run++;
    if ({done, cpu_hold, busy, error, mem_we} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL nominal_done_cycle got=%b exp=10000", {done, cpu_hold, busy, error, mem_we});
    end
    tick();
    tests_run++;
    if ({done, cpu_hold, busy, in_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL nominal_back_idle got=%b exp=0000", {done, cpu_hold, busy, in_ready});
    end
    tests_run++;
    if (wr_n - wb !== 3 || done_n - db !== 1) begin
      tests_failed++;
      $display("FAIL nominal_counts got writes=%0d dones=%0d exp writes=3 dones=1", wr_n - wb, done_n - db);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (wr_addr[wb+i] !== 8'(i) || wr_data[wb+i] !== pay[i]) begin
        tests_failed++;
        $display("FAIL nominal_write%0d got (%h,%h) exp (%h,%h)", i, wr_addr[wb+i], wr_data[wb+i], 8'(i), pay[i]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    int db;
    db = done_n;
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'hA1);
    tests_run++;
    if ({error, cpu_hold, in_ready, busy, done} !== 5'b11000) begin
      tests_failed++;
      $display("FAIL badsum_error_state got=%b exp=11000", {error, cpu_hold, in_ready, busy, done});
    end
    // Error is sticky and further bytes are refused.
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    tests_run++;
    if ({error, cpu_hold, in_ready, mem_we} !== 4'b1100 || done_n != db) begin
      tests_failed++;
      $display("FAIL badsum_sticky got=%b dones=%0d exp=1100 dones=0", {error, cpu_hold, in_ready, mem_we}, done_n - db);
    end
    pulse_start();
    tests_run++;
    if ({error, busy, in_ready, cpu_hold} !== 4'b0111) begin
      tests_failed++;
      $display("FAIL badsum_restart got=%b exp=0111", {error, busy, in_ready, cpu_hold});
    end
    // Finish the restarted load cleanly (L=1, 0x05, checksum 0xFB).
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'hFB);
    tests_run++;
    if ({done, error} !== 2'b10) begin
      tests_failed++;
      $display("FAIL badsum_reload_done got=%b exp=10", {done, error});
    end
    tick();
  endtask

  task automatic test_max_length();
    int wb;
    int bad;
    wb  = wr_n;
    bad = 0;
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      if (i == 254) begin
        tests_run++;
        if (busy !== 1'b1 || mem_addr !== 8'hFE) begin
          tests_failed++;
          $display("FAIL maxlen_still_data got busy=%b addr=%h exp busy=1 addr=FE", busy, mem_addr);
        end
      end
    end
    // In CHECK: the 256th write targets 0xFF and the loader still wants a byte.
    tests_run++;
    if ({mem_we, mem_addr, mem_data, in_ready} !== {1'b1, 8'hFF, 8'hFF, 1'b1}) begin
      tests_failed++;
      $display("FAIL maxlen_last_write got we=%b addr=%h data=%h rdy=%b exp we=1 addr=FF data=FF rdy=1",
               mem_we, mem_addr, mem_data, in_ready);
    end
    send_byte(8'h80);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL maxlen_done got=%b exp=1", done);
    end
    tick();
    for (int i = 0; i < 256; i++)
      if (wr_addr[wb+i] !== 8'(i) || wr_data[wb+i] !== 8'(i)) bad++;
    tests_run++;
    if (wr_n - wb !== 256 || bad != 0) begin
      tests_failed++;
      $display("FAIL maxlen_writes got count=%0d bad=%0d exp count=256 bad=0", wr_n - wb, bad);
    end
  endtask

  task automatic test_backpressure();
    int wb;
    int db;
    logic [7:0] pay [0:2];
    pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30;
    wb = wr_n;
    db = done_n;
    pulse_start();
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      send_byte(pay[i]);
      in_data = 8'hEE;
      tick();
      if (i == 0) begin
        tests_run++;
        if (mem_we !== 1'b0 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_gap got we=%b busy=%b exp we=0 busy=1", mem_we, busy);
        end
      end
    end
    send_byte(8'hA0);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_done got=%b exp=1", done);
    end
    tick();
    tests_run++;
    if (wr_n - wb !== 3 || done_n - db !== 1) begin
      tests_failed++;
      $display("FAIL bp_counts got writes=%0d dones=%0d exp writes=3 dones=1", wr_n - wb, done_n - db);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (wr_addr[wb+i] !== 8'(i) || wr_data[wb+i] !== pay[i]) begin
        tests_failed++;
        $display("FAIL bp_write%0d got (%h,%h) exp (%h,%h)", i, wr_addr[wb+i], wr_data[wb+i], 8'(i), pay[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int wb;
    int db;
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h10);
    // Reset wins over a handshake and a start in the same cycle.
    reset    = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h20;
    tick();
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if ({in_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_data} !== 22'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs got=%h exp=000000",
               {in_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_data});
    end
    tick();
    wb = wr_n;
    db = done_n;
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'hA0);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_reload_done got=%b exp=1", done);
    end
    tick();
    tests_run++;
    if (wr_n - wb !== 3 || wr_addr[wb] !== 8'h00 || wr_addr[wb+2] !== 8'h02 || wr_data[wb+2] !== 8'h30) begin
      tests_failed++;
      $display("FAIL midreset_reload_writes got count=%0d first=%h last=(%h,%h) exp count=3 first=00 last=(02,30)",
               wr_n - wb, wr_addr[wb], wr_addr[wb+2], wr_data[wb+2]);
    end
  endtask

  task automatic test_start_during_data();
    int wb;
    int db;
    wb = wr_n;
    db = done_n;
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h10);
    pulse_start();
    tests_run++;
    if ({busy, in_ready, mem_we} !== 3'b110) begin
      tests_failed++;
      $display("FAIL startdata_ignored got=%b exp=110", {busy, in_ready, mem_we});
    end
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'hA0);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL startdata_done got=%b exp=1", done);
    end
    tick();
    tests_run++;
    if (wr_n - wb !== 3 || done_n - db !== 1 || wr_addr[wb+1] !== 8'h01 || wr_data[wb+1] !== 8'h20) begin
      tests_failed++;
      $display("FAIL startdata_writes got writes=%0d dones=%0d w1=(%h,%h) exp writes=3 dones=1 w1=(01,20)",
               wr_n - wb, done_n - db, wr_addr[wb+1], wr_data[wb+1]);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_max_length();
    test_backpressure();
    test_reset_mid_load();
    test_start_during_data();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
